// File: rtl/init_sequencer_if.sv
// Handshake/bus bundle for init_sequencer: start/status, step-table ROM port,
// byte-writer (cmd) handshake and delay-generator handshake.
// Optional macro INIT_SEQ_ABORT_EN adds the abort input.
interface init_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned MS_W   = 12
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic [ADDR_W-1:0]    rom_addr;
  logic [2+8+MS_W-1:0]  rom_data;
  logic                 cmd_en;
  logic [7:0]           cmd_byte;
  logic                 cmd_fin;
  logic                 delay_en;
  logic [MS_W-1:0]      delay_ms;
  logic                 delay_fin;
`ifdef INIT_SEQ_ABORT_EN
  logic                 abort;
`endif

  // Sequencer side
  modport master (
    input  start, rom_data, cmd_fin, delay_fin,
    output busy, done, ovf, rom_addr, cmd_en, cmd_byte, delay_en, delay_ms
`ifdef INIT_SEQ_ABORT_EN
    , input abort
`endif
  );

  // ROM / writer / delay generator / controller side
  modport slave (
    output start, rom_data, cmd_fin, delay_fin,
    input  busy, done, ovf, rom_addr, cmd_en, cmd_byte, delay_en, delay_ms
`ifdef INIT_SEQ_ABORT_EN
    , output abort
`endif
  );
endinterface

// File: rtl/init_sequencer.sv
// Step-table sequencer: walks an external combinational ROM and, per entry,
// issues a command byte over cmd_en/cmd_fin, a millisecond delay over
// delay_en/delay_fin, or both. Entry = {type[1:0], byte[7:0], ms[MS_W-1:0]}.
// Optional macro INIT_SEQ_ABORT_EN adds an abort input that returns to IDLE.
module init_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned MS_W   = 12
) (
  input logic               clk,
  input logic               rst,
  init_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StCmd, StCmdRel, StDly, StDlyRel, StNext, StDone
  } state_e;

  localparam logic [1:0] TyCmd    = 2'b00;
  localparam logic [1:0] TyDly    = 2'b01;
  localparam logic [1:0] TyCmdDly = 2'b10;

  state_e            r_state;
  logic [1:0]        r_type;
  logic [MS_W-1:0]   r_ms;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cmd_en;
  logic [7:0]        r_cmd_byte;
  logic              r_delay_en;
  logic [MS_W-1:0]   r_delay_ms;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;

  logic [1:0]        w_type;
  logic [7:0]        w_byte;
  logic [MS_W-1:0]   w_ms;
  logic              w_abort;

  assign w_type = bus.rom_data[MS_W+9:MS_W+8];
  assign w_byte = bus.rom_data[MS_W+7:MS_W];
  assign w_ms   = bus.rom_data[MS_W-1:0];

`ifdef INIT_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign bus.rom_addr = r_addr;
  assign bus.cmd_en   = r_cmd_en;
  assign bus.cmd_byte = r_cmd_byte;
  assign bus.delay_en = r_delay_en;
  assign bus.delay_ms = r_delay_ms;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ovf      = r_ovf;

  // Sequencer FSM with all outputs registered; abort outranks start and fins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_type     <= TyCmd;
      r_ms       <= '0;
      r_addr     <= '0;
      r_cmd_en   <= 1'b0;
      r_cmd_byte <= 8'h00;
      r_delay_en <= 1'b0;
      r_delay_ms <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_abort && (r_state != StIdle)) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_cmd_en   <= 1'b0;
      r_delay_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            r_state <= StFetch;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        StFetch: begin
          r_type <= w_type;
          r_ms   <= w_ms;
          case (w_type)
            TyCmd, TyCmdDly: begin
              r_state    <= StCmd;
              r_cmd_en   <= 1'b1;
              r_cmd_byte <= w_byte;
            end
            TyDly: begin
              r_state    <= StDly;
              r_delay_en <= 1'b1;
              r_delay_ms <= w_ms;
            end
            default: begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          endcase
        end
        StCmd: begin
          if (bus.cmd_fin) begin
            r_cmd_en <= 1'b0;
            r_state  <= StCmdRel;
          end
        end
        StCmdRel: begin
          if (r_type == TyCmdDly) begin
            r_state    <= StDly;
            r_delay_en <= 1'b1;
            r_delay_ms <= r_ms;
          end else begin
            r_state <= StNext;
          end
        end
        StDly: begin
          if (bus.delay_fin) begin
            r_delay_en <= 1'b0;
            r_state    <= StDlyRel;
          end
        end
        StDlyRel: r_state <= StNext;
        StNext: begin
          // Last table slot reached without END: stop rather than wrap.
          if (&r_addr) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ovf   <= 1'b1;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= StFetch;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Bench for init_sequencer: ROM table, byte-writer and delay generator with
// programmable latency, a transaction-level expectation model and directed tests.
module tb_init_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  init_sequencer_if #(.ADDR_W(2), .MS_W(12)) bus_if ();

  init_sequencer #(.ADDR_W(2), .MS_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [21:0] rom [4];
  assign bus_if.rom_data = rom[bus_if.rom_addr];

  int n_vec = 0;
  int n_err = 0;
  int cmd_lat = 1;
  int dly_lat = 1;
  int n_cmd = 0;
  bit chk_on = 1'b0;

  typedef struct packed {
    logic        is_dly;
    logic [11:0] val;
  } item_t;

  item_t      exp_q[$];
  logic [1:0] exp_addr;
  logic       exp_ovf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] ent(input logic [1:0] ty, input logic [7:0] b,
                                      input logic [11:0] ms);
    return {ty, b, ms};
  endfunction

  // Expected transactions: walk the table as the rules describe it.
  function void build_expect();
    logic [1:0] ty;
    exp_q.delete();
    exp_ovf  = 1'b1;
    exp_addr = 2'd3;
    for (int a = 0; a < 4; a++) begin
      ty = rom[a][21:20];
      if (ty == 2'b11) begin
        exp_ovf  = 1'b0;
        exp_addr = 2'(a);
        break;
      end
      if (ty != 2'b01) exp_q.push_back('{1'b0, {4'h0, rom[a][19:12]}});
      if (ty != 2'b00) exp_q.push_back('{1'b1, rom[a][11:0]});
    end
  endfunction

  // Byte-writer: cmd_fin after cmd_en has been seen high cmd_lat cycles.
  initial begin : cmd_writer
    int n;
    n = 0;
    bus_if.cmd_fin = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.cmd_fin = 1'b0;
      if (bus_if.cmd_en) begin
        n++;
        if (n >= cmd_lat) begin
          bus_if.cmd_fin = 1'b1;
          n = 0;
        end
      end else n = 0;
    end
  end

  // Delay generator: delay_fin after delay_en has been seen high dly_lat cycles.
  initial begin : dly_gen
    int n;
    n = 0;
    bus_if.delay_fin = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.delay_fin = 1'b0;
      if (bus_if.delay_en) begin
        n++;
        if (n >= dly_lat) begin
          bus_if.delay_fin = 1'b1;
          n = 0;
        end
      end else n = 0;
    end
  end

  // Per-cycle comparison against the transaction model.
  initial begin : compare
    logic pc, pd, pdone;
    int run;
    item_t cur;
    logic [1:0] exp_kind;
    pc = 0; pd = 0; pdone = 0; run = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!chk_on) begin
        pc = bus_if.cmd_en; pd = bus_if.delay_en; pdone = bus_if.done; run = 0;
        continue;
      end
      check("enables_exclusive", {31'd0, bus_if.cmd_en & bus_if.delay_en}, 0);
      check("busy_done_exclusive", {31'd0, bus_if.busy & bus_if.done}, 0);
      if (pc && !bus_if.cmd_en) check("cmd_en_length", run, cmd_lat);
      if (pd && !bus_if.delay_en) check("delay_en_length", run, dly_lat);
      if ((bus_if.cmd_en && !pc) || (bus_if.delay_en && !pd)) begin
        exp_kind = (exp_q.size() == 0) ? 2'b00 : (exp_q[0].is_dly ? 2'b10 : 2'b01);
        check("step_kind", {30'd0, bus_if.delay_en, bus_if.cmd_en}, {30'd0, exp_kind});
        check("low_gap_before_enable", {31'd0, pc | pd}, 0);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        if (bus_if.cmd_en) n_cmd++;
        run = 0;
      end
      if (bus_if.cmd_en) begin
        check("cmd_byte", bus_if.cmd_byte, cur.val[7:0]);
        run++;
      end
      if (bus_if.delay_en) begin
        check("delay_ms", bus_if.delay_ms, cur.val);
        run++;
      end
      if (bus_if.done && !pdone) begin
        check("steps_left_at_done", exp_q.size(), 0);
        check("rom_addr_at_done", bus_if.rom_addr, exp_addr);
        check("ovf_at_done", bus_if.ovf, exp_ovf);
      end
      pc = bus_if.cmd_en; pd = bus_if.delay_en; pdone = bus_if.done;
    end
  end

  function automatic logic sig_val(input int which);
    case (which)
      0:       return bus_if.cmd_en;
      1:       return bus_if.delay_en;
      2:       return bus_if.done;
      default: return !bus_if.cmd_en;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig_val(which)) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic run_table(input string name);
    build_expect();
    chk_on = 1'b1;
    pulse_start();
    wait_for(name, 2, 400);
  endtask

  initial begin : main
    rst = 1'b1;
    bus_if.start = 1'b0;
`ifdef INIT_SEQ_ABORT_EN
    bus_if.abort = 1'b0;
`endif
    for (int i = 0; i < 4; i++) rom[i] = ent(2'b11, 8'h00, 12'd0);
    repeat (2) @(negedge clk);
    check("rst_rom_addr", bus_if.rom_addr, 0);
    check("rst_cmd_en", bus_if.cmd_en, 0);
    check("rst_cmd_byte", bus_if.cmd_byte, 0);
    check("rst_delay_en", bus_if.delay_en, 0);
    check("rst_delay_ms", bus_if.delay_ms, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_ovf", bus_if.ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // CMD 0xAE, DLY 3, END
    rom[0] = ent(2'b00, 8'hAE, 12'd0);
    rom[1] = ent(2'b01, 8'h00, 12'd3);
    rom[2] = ent(2'b11, 8'h00, 12'd0);
    build_expect();
    chk_on = 1'b1;
    pulse_start();
    check("busy_after_start", bus_if.busy, 1);
    wait_for("t1_done", 2, 200);
    check("t1_done", bus_if.done, 1);
    check("t1_ovf", bus_if.ovf, 0);
    check("t1_rom_addr", bus_if.rom_addr, 2);
    check("t1_busy", bus_if.busy, 0);

    // Restart from DONE re-runs the whole table
    cmd_lat = 3; dly_lat = 2;
    run_table("t1_rerun_done");
    check("t1_rerun_rom_addr", bus_if.rom_addr, 2);

    // CMD_DLY 0x8D/100, END; delay_en rises two cycles after the cmd_fin cycle
    chk_on = 1'b0;
    rom[0] = ent(2'b10, 8'h8D, 12'd100);
    rom[1] = ent(2'b11, 8'h00, 12'd0);
    cmd_lat = 5; dly_lat = 10;
    build_expect();
    chk_on = 1'b1;
    pulse_start();
    wait_for("t2_cmd_en", 0, 50);
    wait_for("t2_cmd_release", 3, 50);
    check("t2_release_cycle_delay_en", bus_if.delay_en, 0);
    @(negedge clk);
    check("t2_delay_en_rise", bus_if.delay_en, 1);
    check("t2_delay_ms", bus_if.delay_ms, 100);
    wait_for("t2_done", 2, 200);
    check("t2_ovf", bus_if.ovf, 0);
    check("t2_rom_addr", bus_if.rom_addr, 1);

    // No END entry: four commands, then overflow
    chk_on = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = ent(2'b00, 8'(8'h11 * (i + 1)), 12'd0);
    cmd_lat = 2;
    n_cmd = 0;
    run_table("t3_done");
    check("t3_cmd_count", n_cmd, 4);
    check("t3_ovf", bus_if.ovf, 1);
    check("t3_rom_addr", bus_if.rom_addr, 3);

    // start while in DLY is ignored
    chk_on = 1'b0;
    rom[0] = ent(2'b00, 8'hAE, 12'd0);
    rom[1] = ent(2'b01, 8'h00, 12'd3);
    rom[2] = ent(2'b11, 8'h00, 12'd0);
    cmd_lat = 1; dly_lat = 10;
    build_expect();
    chk_on = 1'b1;
    pulse_start();
    wait_for("t5_delay_en", 1, 50);
    pulse_start();
    @(negedge clk);
    check("t5_delay_en_held", bus_if.delay_en, 1);
    check("t5_delay_ms_held", bus_if.delay_ms, 3);
    check("t5_rom_addr_held", bus_if.rom_addr, 1);
    wait_for("t5_done", 2, 200);
    check("t5_rom_addr", bus_if.rom_addr, 2);

    // Reset in the middle of a delay handshake, then restart from address 0
    chk_on = 1'b0;
    dly_lat = 20;
    pulse_start();
    wait_for("t4_delay_en", 1, 50);
    rst = 1'b1;
    #1;
    check("t4_rst_delay_en", bus_if.delay_en, 0);
    check("t4_rst_busy", bus_if.busy, 0);
    check("t4_rst_done", bus_if.done, 0);
    check("t4_rst_rom_addr", bus_if.rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dly_lat = 2;
    run_table("t4_restart_done");
    check("t4_restart_rom_addr", bus_if.rom_addr, 2);

`ifdef INIT_SEQ_ABORT_EN
    // Abort during a command handshake
    chk_on = 1'b0;
    cmd_lat = 20;
    pulse_start();
    wait_for("ab_cmd_en", 0, 50);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("ab_cmd_en", bus_if.cmd_en, 0);
    check("ab_rom_addr", bus_if.rom_addr, 0);
    check("ab_busy", bus_if.busy, 0);
    check("ab_done", bus_if.done, 0);
    repeat (3) @(negedge clk);
    check("ab_stays_idle", bus_if.cmd_en | bus_if.busy, 0);
`endif

    chk_on = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
Initiator side of the delay_en/delay_fin handshake, and of an equivalent cmd_en/cmd_fin handshake to a byte-writer. Walks a step table held in an external combinational ROM, addressed by this block. For each step it issues a command byte, requests a millisecond delay, or both. Used to drive display/peripheral power-up and initialisation sequences.

Parameters:
ADDR_W, 5, step-table address width; table holds at most 2^ADDR_W entries
MS_W, 12, width of the delay field and of delay_ms

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; begins the sequence from address 0
rom_addr  out  ADDR_W  step-table address
rom_data  in  2+8+MS_W  step entry {type[1:0], byte[7:0], ms[MS_W-1:0]}, valid in the same cycle as rom_addr
cmd_en  out  1  command request; held high until cmd_fin
cmd_byte  out  8  command byte; stable while cmd_en=1
cmd_fin  in  1  command complete; only meaningful while cmd_en=1
delay_en  out  1  delay request; held high until delay_fin
delay_ms  out  MS_W  requested delay in ms; stable while delay_en=1
delay_fin  in  1  delay complete; only meaningful while delay_en=1
busy  out  1  high from the cycle after start until DONE or IDLE
done  out  1  high in DONE; sequence completed
ovf  out  1  set in DONE if the table ended without an END entry

Behaviour:
- All outputs are registered. Reset values: state IDLE, rom_addr 0, cmd_en 0, cmd_byte 0, delay_en 0, delay_ms 0, busy 0, done 0, ovf 0. Reset acts immediately at any point, including mid-handshake.
- Entry type encoding: 00 CMD (send byte only), 01 DLY (delay only), 10 CMD_DLY (send byte, then delay), 11 END.
- IDLE: start=1 -> FETCH; rom_addr<=0, busy<=1, done<=0, ovf<=0.
- FETCH (1 cycle): latch rom_data into type/byte/ms registers.
  - CMD or CMD_DLY -> CMD state; cmd_en<=1, cmd_byte<=byte.
  - DLY -> DLY state; delay_en<=1, delay_ms<=ms.
  - END -> DONE.
- CMD: hold cmd_en and cmd_byte. When cmd_fin=1: cmd_en<=0 -> CMD_REL.
- CMD_REL (exactly 1 cycle, both enables low):
  - type CMD_DLY -> DLY; delay_en<=1, delay_ms<=ms.
  - otherwise -> NEXT.
- DLY: hold delay_en and delay_ms. When delay_fin=1: delay_en<=0 -> DLY_REL.
- DLY_REL (exactly 1 cycle, enables low) -> NEXT. The guaranteed low cycle lets the delay generator return to idle before the next request.
- NEXT: if rom_addr == 2^ADDR_W-1 -> DONE with ovf<=1 (no wrap). Otherwise rom_addr<=rom_addr+1 -> FETCH.
- DONE: done=1, busy=0, rom_addr held. start=1 -> restart exactly as from IDLE.
- start is ignored in every state except IDLE and DONE.
- delay_en and cmd_en are never high in the same cycle.
- ms=0 is legal and is passed to the delay generator unchanged.
- Minimum step cost: CMD = 3 cycles + writer latency; DLY = 3 cycles + generator latency.
- cmd_fin or delay_fin arriving while the matching enable is low is ignored.

Optional Feature:
INIT_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state -> next cycle: state IDLE, cmd_en=0, delay_en=0, busy=0, done=0, rom_addr=0. abort has priority over start and over any fin input.
- Undefined: no abort port. The sequence can only be stopped by rst.

Test Plan:
- Table {CMD 0xAE, DLY 3, END}; start pulse -> cmd_en high with cmd_byte=0xAE until cmd_fin; 1 cycle with both enables low; delay_en high with delay_ms=3 until delay_fin; then done=1, ovf=0, rom_addr=2.
- Table {CMD_DLY 0x8D/100, END}; cmd_fin after 5 cycles, delay_fin after 10 -> delay_en rises exactly 2 cycles after cmd_fin, delay_ms=100; done follows.
- Table of all-CMD entries with no END, ADDR_W=2 -> exactly 4 commands issued, then done=1, ovf=1, rom_addr=3.
- rst asserted while delay_en=1 -> delay_en, busy and done low immediately; a new start restarts from address 0.
- In DONE, a start pulse re-runs the full table; start pulsed while in DLY is ignored (delay_ms and rom_addr unchanged).
- With INIT_SEQ_ABORT_EN defined: abort while cmd_en=1 -> next cycle cmd_en=0, state IDLE, rom_addr=0; a cmd_fin in that same cycle has no effect.
